// File: rtl/grid_click_decoder.sv
// rtl/grid_click_decoder.sv - mouse pixel click to packed board cell index with phase-steered pulse
module grid_click_decoder #(
    parameter int X0   = 64,
    parameter int Y0   = 64,
    parameter int CELL = 48,
    parameter int GRID = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    input  logic        enable,
    input  logic        phase,
    output logic [7:0]  mouse_pos,
    output logic        pick_ship,
    output logic        fire,
    output logic        busy
);

    // 13-bit bounds so the far grid edge cannot wrap for any 12-bit origin
    localparam logic [12:0] X_LO   = 13'(X0);
    localparam logic [12:0] X_HI   = 13'(X0 + GRID * CELL);
    localparam logic [12:0] Y_LO   = 13'(Y0);
    localparam logic [12:0] Y_HI   = 13'(Y0 + GRID * CELL);
    localparam logic [11:0] X0_W   = 12'(X0);
    localparam logic [11:0] Y0_W   = 12'(Y0);
    localparam logic [11:0] CELL_W = 12'(CELL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RANGE,
        S_DIV,
        S_EMIT,
        S_WAIT_REL
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        left_d;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic        ph_q;
    logic [11:0] dx;
    logic [11:0] dy;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        click;
    logic        out_of_grid;
    logic        div_done;
    logic        emit_now;

    assign click       = left & ~left_d;
    assign out_of_grid = ({1'b0, x_q} < X_LO) || ({1'b0, x_q} >= X_HI) ||
                         ({1'b0, y_q} < Y_LO) || ({1'b0, y_q} >= Y_HI);
    assign div_done    = (dx < CELL_W) && (dy < CELL_W);
    // Dropping enable on the finishing DIV cycle suppresses the pulse too
    assign emit_now    = (state == S_DIV) && div_done && enable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (click && enable) begin
                    state_nxt = S_RANGE;
                end
            end
            S_RANGE: begin
                if (!enable || out_of_grid) begin
                    state_nxt = S_WAIT_REL;
                end else begin
                    state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (!enable) begin
                    state_nxt = S_WAIT_REL;
                end else if (div_done) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!left) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            left_d    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            ph_q      <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            row       <= '0;
            col       <= '0;
            mouse_pos <= 8'h00;
            pick_ship <= 1'b0;
            fire      <= 1'b0;
        end else begin
            left_d <= left;
            case (state)
                S_IDLE: begin
                    if (click && enable) begin
                        x_q  <= xpos;
                        y_q  <= ypos;
                        ph_q <= phase;
                    end
                end
                S_RANGE: begin
                    dx  <= x_q - X0_W;
                    dy  <= y_q - Y0_W;
                    row <= '0;
                    col <= '0;
                end
                S_DIV: begin
                    // x and y reduce independently; a pixel on a boundary lands in the higher cell
                    if (dx >= CELL_W) begin
                        dx  <= dx - CELL_W;
                        col <= col + 4'd1;
                    end
                    if (dy >= CELL_W) begin
                        dy  <= dy - CELL_W;
                        row <= row + 4'd1;
                    end
                end
                default: begin
                end
            endcase
            if (emit_now) begin
                mouse_pos <= {row, col};
            end
            pick_ship <= emit_now & ~ph_q;
            fire      <= emit_now & ph_q;
        end
    end

endmodule

// File: tb/tb_grid_click_decoder.sv
// tb/tb_grid_click_decoder.sv - self-checking bench for grid_click_decoder
module tb_grid_click_decoder;

    localparam int X0   = 64;
    localparam int Y0   = 64;
    localparam int CELL = 48;
    localparam int GRID = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        enable;
    logic        phase;
    logic [7:0]  mouse_pos;
    logic        pick_ship;
    logic        fire;
    logic        busy;

    grid_click_decoder #(.X0(X0), .Y0(Y0), .CELL(CELL), .GRID(GRID)) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left),
        .enable(enable), .phase(phase), .mouse_pos(mouse_pos),
        .pick_ship(pick_ship), .fire(fire), .busy(busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_s = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    // Expectations published by the stimulus process
    logic       chk_on   = 1'b0;
    logic       pend     = 1'b0;
    int         pend_cyc = 0;
    logic [7:0] pend_pos = 8'h00;
    logic       pend_ph  = 1'b0;
    int         busy_exp = 0;
    logic       lit_on   = 1'b0;
    int         lit_cyc  = 0;
    logic [7:0] lit_pos  = 8'h00;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_pos = 8'h00;
    logic       exp_p;
    logic       exp_f;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (!rst_s) begin
                model_pos = 8'h00;
            end else if (pend && cyc == pend_cyc) begin
                model_pos = pend_pos;
            end
            exp_p = rst_s && pend && (cyc == pend_cyc) && !pend_ph;
            exp_f = rst_s && pend && (cyc == pend_cyc) && pend_ph;
            check("pick_ship", {31'd0, pick_ship}, {31'd0, exp_p});
            check("fire", {31'd0, fire}, {31'd0, exp_f});
            check("mouse_pos", {24'd0, mouse_pos}, {24'd0, model_pos});
            if (busy_exp != 2) begin
                check("busy", {31'd0, busy}, 32'(busy_exp));
            end
            if (lit_on && (pick_ship || fire)) begin
                check("lit_pulse_cycle", 32'(cyc), 32'(lit_cyc));
                check("lit_pos", {24'd0, mouse_pos}, {24'd0, lit_pos});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a press; returns the edge index k at which the click is sampled
    task automatic click(input int x, input int y, input logic ph, input logic en, output int k);
        int c;
        int r;
        int m;
        bit ing;
        xpos   = 12'(x);
        ypos   = 12'(y);
        phase  = ph;
        enable = en;
        left   = 1'b1;
        k      = cyc + 1;
        ing    = (x >= X0) && (x < X0 + GRID * CELL) && (y >= Y0) && (y < Y0 + GRID * CELL);
        if (en && ing) begin
            c        = (x - X0) / CELL;
            r        = (y - Y0) / CELL;
            m        = (c > r) ? c : r;
            pend_cyc = k + 2 + m;
            pend_pos = {4'(r), 4'(c)};
            pend_ph  = ph;
            pend     = 1'b1;
        end else begin
            pend = 1'b0;
        end
        tick();
        if (en) busy_exp = 1;
    endtask

    task automatic release_btn();
        left = 1'b0;
        tick();
        busy_exp = 0;
        lit_on   = 1'b0;
        tick();
    endtask

    task automatic run_click(input int x, input int y, input logic ph,
                             input logic lit, input int lat, input logic [7:0] lpos);
        int k;
        click(x, y, ph, 1'b1, k);
        lit_on  = lit;
        lit_cyc = k + lat;
        lit_pos = lpos;
        repeat (14) tick();
        release_btn();
    endtask

    typedef struct {
        int   x;
        int   y;
        logic ph;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        rst = 1'b0; xpos = '0; ypos = '0; left = 1'b0; enable = 1'b1; phase = 1'b0;
        repeat (3) tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Setup click at the grid origin, then the right edge and just past it
        run_click(64, 64, 1'b0, 1'b1, 2, 8'h00);
        run_click(543, 100, 1'b0, 1'b1, 11, 8'h09);
        run_click(544, 100, 1'b0, 1'b0, 0, 8'h00);

        // Battle click; inputs scrambled right after capture
        click(200, 300, 1'b1, 1'b1, k);
        lit_on = 1'b1; lit_cyc = k + 6; lit_pos = 8'h42;
        xpos = 12'd700; ypos = 12'd5; phase = 1'b0;
        repeat (13) tick();
        release_btn();

        // Held button: single pulse, then a second press pulses again
        click(300, 150, 1'b0, 1'b1, k);
        lit_on = 1'b1; lit_cyc = k + 6; lit_pos = 8'h14;
        repeat (50) tick();
        release_btn();
        run_click(300, 150, 1'b0, 1'b1, 6, 8'h14);

        // Boundary table checked against the model only
        vecs[0] = '{x: 112, y: 208, ph: 1'b0};
        vecs[1] = '{x: 543, y: 543, ph: 1'b1};
        vecs[2] = '{x: 63,  y: 100, ph: 1'b0};
        vecs[3] = '{x: 100, y: 544, ph: 1'b1};
        vecs[4] = '{x: 100, y: 63,  ph: 1'b0};
        vecs[5] = '{x: 159, y: 160, ph: 1'b1};
        foreach (vecs[i]) run_click(vecs[i].x, vecs[i].y, vecs[i].ph, 1'b0, 0, 8'h00);
        run_click(112, 208, 1'b0, 1'b1, 5, 8'h31);

        // Abort by dropping enable on the third DIV cycle
        click(543, 543, 1'b0, 1'b1, k);
        repeat (3) tick();
        enable = 1'b0;
        pend   = 1'b0;
        repeat (8) tick();
        release_btn();
        enable = 1'b1;

        // Click while disabled is ignored outright
        click(300, 300, 1'b1, 1'b0, k);
        repeat (6) tick();
        release_btn();
        enable = 1'b1;

        // Reset in the middle of a conversion
        click(543, 543, 1'b1, 1'b1, k);
        repeat (3) tick();
        rst  = 1'b0;
        left = 1'b0;
        pend = 1'b0;
        tick();
        busy_exp = 0;
        rst = 1'b1;
        repeat (3) tick();
        run_click(200, 300, 1'b0, 1'b1, 6, 8'h42);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
